mem_queue_stage: RTL and testbench

- Parametrised successor to the single-entry memory pipeline stage.
- Buffers up to DEPTH memory requests (read_enable, write_enable, addr, data, id) between two std_mem_intf ports in strict FIFO order.
- Adds an occupancy count, an almost-full flag, a synchronous flush, and a zero-latency fall-through mode.
- Placement: between a core's load/store unit and the memory arbiter or cache, to absorb back-pressure bursts.

---
 rtl/mem_pkg.sv | 34 +++
 rtl/std_mem_intf.sv | 32 +++
 rtl/mem_queue_ctrl.sv | 94 +++++++++
 rtl/mem_queue_stage.sv | 124 ++++++++++++
 tb/tb_mem_queue_stage.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory request queue family.
//   mem_queue_mode_t      - output timing of a queue stage (registered / fall-through)
//   MEM_QUEUE_DEPTH_MIN/MAX - legal depth range for queue stages
//   mem_ptr_width()       - pointer width for a circular array of a given depth
//   `MEM_PARAM_RANGE_CHECK - elaboration-time parameter range check, usable in
//                           any module scope that includes this file first
`ifndef MEM_PKG_SV
`define MEM_PKG_SV

// Expands to a generate-if that stops elaboration when VAL is outside LO..HI.
`define MEM_PARAM_RANGE_CHECK(LABEL, VAL, LO, HI) \
  if (((VAL) < (LO)) || ((VAL) > (HI))) begin : LABEL \
    $error("mem parameter out of range"); \
  end

package mem_pkg;

  typedef enum logic {
    MEM_QUEUE_REGISTERED   = 1'b0,
    MEM_QUEUE_FALL_THROUGH = 1'b1
  } mem_queue_mode_t;

  localparam int MEM_QUEUE_DEPTH_MIN = 2;
  localparam int MEM_QUEUE_DEPTH_MAX = 256;

  // Pointer width for DEPTH entries; at least one bit so a depth of 1 still
  // yields a legal vector.
  function automatic int mem_ptr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

`endif

// File: rtl/std_mem_intf.sv
// std_mem_intf: valid/ready memory request channel.
//   valid/ready   - handshake, transfer when both are high on a rising clock edge
//   read_enable   - read request flag
//   write_enable  - write (byte) enables, WE_W bits
//   addr/data/id  - request address, write data and transaction tag
// Modport "in" is the receiving side, modport "out" the sending side.
interface std_mem_intf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int WE_W   = 4
);

  logic              valid;
  logic              ready;
  logic              read_enable;
  logic [WE_W-1:0]   write_enable;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic [ID_W-1:0]   id;

  modport in (
    input  valid, read_enable, write_enable, addr, data, id,
    output ready
  );

  modport out (
    output valid, read_enable, write_enable, addr, data, id,
    input  ready
  );

endinterface

// File: rtl/mem_queue_ctrl.sv
// mem_queue_ctrl: occupancy bookkeeping for a circular queue of DEPTH entries.
// Holds no payload, so request and response queues can share it.
//   clk, rst      - clock, asynchronous active-low reset
//   flush         - synchronous clear of pointers, count and almost_full
//   push, pop     - one entry written / one entry consumed this cycle
//   rd_ptr/wr_ptr - head and tail slot indices (wrap DEPTH-1 -> 0)
//   count         - stored entries, 0..DEPTH
//   almost_full   - registered (count >= ALMOST_FULL)
//   empty, full   - decoded from count
`include "mem_pkg.sv"

module mem_queue_ctrl
  import mem_pkg::*;
#(
  parameter  int DEPTH       = 4,
  parameter  int ALMOST_FULL = DEPTH - 1,
  localparam int CW          = $clog2(DEPTH + 1),
  localparam int PW          = mem_ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  output logic [PW-1:0] rd_ptr,
  output logic [PW-1:0] wr_ptr,
  output logic [CW-1:0] count,
  output logic          almost_full,
  output logic          empty,
  output logic          full
);

  `MEM_PARAM_RANGE_CHECK(g_chk_depth, DEPTH, MEM_QUEUE_DEPTH_MIN, MEM_QUEUE_DEPTH_MAX)
  `MEM_PARAM_RANGE_CHECK(g_chk_af, ALMOST_FULL, 1, DEPTH)

  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(ALMOST_FULL);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          af_q, af_d;

  // Explicit wrap compare: DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push) - CW'(pop);
    end
    // Registered flag tracks the count it will be paired with next cycle.
    af_d = (count_d >= AF_C);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      af_q     <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      af_q     <= af_d;
    end
  end

  assign rd_ptr      = rd_ptr_q;
  assign wr_ptr      = wr_ptr_q;
  assign count       = count_q;
  assign almost_full = af_q;
  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_C);

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && !flush && (count_q == DEPTH_C)));

  a_no_underflow : assert property (@(posedge clk) disable iff (!rst)
    !(pop && !push && !flush && (count_q == '0)));

endmodule

// File: rtl/mem_queue_stage.sv
// mem_queue_stage: FIFO of up to DEPTH memory requests between two
// std_mem_intf channels, absorbing back-pressure from the memory side.
//   clk, rst     - clock, asynchronous active-low reset (queued requests lost)
//   flush        - synchronous discard of all entries; blocks both handshakes
//   mem_in       - request input (receiving side)
//   mem_out      - request output (sending side), same field widths as mem_in
//   count        - stored entries, 0..DEPTH
//   almost_full  - registered (count >= ALMOST_FULL)
// MODE selects registered output (1-cycle minimum latency) or fall-through,
// where an empty queue presents mem_in directly on mem_out.
`include "mem_pkg.sv"

module mem_queue_stage
  import mem_pkg::*;
#(
  parameter int              DEPTH       = 4,
  parameter mem_queue_mode_t MODE        = MEM_QUEUE_REGISTERED,
  parameter int              ALMOST_FULL = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  std_mem_intf.in                      mem_in,
  std_mem_intf.out                     mem_out,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = mem_ptr_width(DEPTH);
  localparam int AW = $bits(mem_in.addr);
  localparam int DW = $bits(mem_in.data);
  localparam int IW = $bits(mem_in.id);
  localparam int WW = $bits(mem_in.write_enable);
  localparam bit FALL_THROUGH = (MODE == MEM_QUEUE_FALL_THROUGH);

  `MEM_PARAM_RANGE_CHECK(g_chk_depth, DEPTH, MEM_QUEUE_DEPTH_MIN, MEM_QUEUE_DEPTH_MAX)
  `MEM_PARAM_RANGE_CHECK(g_chk_af, ALMOST_FULL, 1, DEPTH)

  if ((AW != $bits(mem_out.addr)) || (DW != $bits(mem_out.data)) ||
      (IW != $bits(mem_out.id))   || (WW != $bits(mem_out.write_enable))) begin : g_chk_width
    $error("mem_queue_stage: mem_in and mem_out field widths differ");
  end

  typedef struct packed {
    logic          read_enable;
    logic [WW-1:0] write_enable;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [IW-1:0] id;
  } mem_t;

  mem_t          storage_q [DEPTH];
  mem_t          in_req;
  mem_t          head_req;
  mem_t          out_req;

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_int;
  logic          empty;
  logic          full;

  logic          in_ready;
  logic          out_valid;
  logic          bypass;
  logic          push;
  logic          push_stored;
  logic          pop;
  logic          pass_through;

  assign in_req   = {mem_in.read_enable, mem_in.write_enable, mem_in.addr,
                     mem_in.data, mem_in.id};
  assign head_req = storage_q[rd_ptr];

  always_comb begin
    // Ready depends only on local state, never on mem_out.ready, so no
    // combinational ready path crosses the stage. A slot freed by a pop
    // while full is only offered on the following cycle.
    in_ready     = !full && !flush;
    push         = mem_in.valid && in_ready;
    // Fall-through only when empty; otherwise the head must be served first.
    bypass       = FALL_THROUGH && empty && mem_in.valid;
    // rst gates valid so an asynchronous reset drops it immediately even
    // while a fall-through request is being presented.
    out_valid    = rst && !flush && (!empty || bypass);
    out_req      = bypass ? in_req : head_req;
    pop          = out_valid && mem_out.ready && !empty;
    pass_through = bypass && push && mem_out.ready;
    push_stored  = push && !pass_through;
  end

  // Payload storage carries no reset; entries are only read when counted.
  always_ff @(posedge clk) begin
    if (push_stored) storage_q[wr_ptr] <= in_req;
  end

  mem_queue_ctrl #(
    .DEPTH       (DEPTH),
    .ALMOST_FULL (ALMOST_FULL)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .push        (push_stored),
    .pop         (pop),
    .rd_ptr      (rd_ptr),
    .wr_ptr      (wr_ptr),
    .count       (count_int),
    .almost_full (almost_full),
    .empty       (empty),
    .full        (full)
  );

  assign mem_in.ready         = in_ready;
  assign mem_out.valid        = out_valid;
  assign mem_out.read_enable  = out_req.read_enable;
  assign mem_out.write_enable = out_req.write_enable;
  assign mem_out.addr         = out_req.addr;
  assign mem_out.data         = out_req.data;
  assign mem_out.id           = out_req.id;
  assign count                = count_int;

endmodule

// File: tb/tb_mem_queue_stage.sv
// Three instances: 0 = DEPTH 4 registered, 1 = DEPTH 3 registered,
// 2 = DEPTH 4 fall-through. Expected outputs are queued with the instance
// index when stimulus is issued; the monitor pops and compares on every
// output handshake.
`include "mem_pkg.sv"

module tb_mem_queue_stage;
  import mem_pkg::*;

  typedef struct packed {
    logic        re;
    logic [3:0]  we;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  id;
  } pkt_t;

  typedef struct packed {
    logic [1:0] inst;
    pkt_t       p;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pkt_t       drv_pkt [3];
  logic [2:0] drv_valid;
  logic [2:0] drv_ready;
  logic [2:0] drv_flush;
  pkt_t       o_pkt [3];
  logic [2:0] o_valid;
  logic [2:0] i_ready;
  logic [2:0] o_af;
  logic [2:0] o_count [3];

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D = (g == 1) ? 3 : 4;
    localparam mem_queue_mode_t M = (g == 2) ? MEM_QUEUE_FALL_THROUGH : MEM_QUEUE_REGISTERED;
    std_mem_intf #(.ADDR_W(16), .DATA_W(32), .ID_W(4), .WE_W(4)) in_if ();
    std_mem_intf #(.ADDR_W(16), .DATA_W(32), .ID_W(4), .WE_W(4)) out_if ();
    logic [$clog2(D+1)-1:0] cnt;
    logic                   af;

    assign in_if.valid        = drv_valid[g];
    assign in_if.read_enable  = drv_pkt[g].re;
    assign in_if.write_enable = drv_pkt[g].we;
    assign in_if.addr         = drv_pkt[g].addr;
    assign in_if.data         = drv_pkt[g].data;
    assign in_if.id           = drv_pkt[g].id;
    assign out_if.ready       = drv_ready[g];
    assign o_valid[g]         = out_if.valid;
    assign o_pkt[g]           = {out_if.read_enable, out_if.write_enable, out_if.addr,
                                 out_if.data, out_if.id};
    assign i_ready[g]         = in_if.ready;
    assign o_count[g]         = 3'(cnt);
    assign o_af[g]            = af;

    mem_queue_stage #(.DEPTH(D), .MODE(M)) u_dut (
      .clk         (clk),
      .rst         (rst_n),
      .flush       (drv_flush[g]),
      .mem_in      (in_if),
      .mem_out     (out_if),
      .count       (cnt),
      .almost_full (af)
    );
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic pkt_t mk(input logic [3:0] id, input logic [15:0] addr,
                              input logic [31:0] data, input logic [3:0] we, input logic re);
    pkt_t p;
    p.re = re; p.we = we; p.addr = addr; p.data = data; p.id = id;
    return p;
  endfunction

  task automatic expect_out(input int k, input pkt_t p);
    exp_t e;
    e.inst = 2'(k);
    e.p    = p;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every output handshake must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (o_valid[k] && drv_ready[k]) begin
          n_chk++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_out inst%0d: got id %0h, expected no output", k, o_pkt[k].id);
          end else begin
            e = exp_q.pop_front();
            if (e.inst == 2'(k) && e.p == o_pkt[k]) n_pass++;
            else $display("FAIL out_pkt inst%0d: got %h, expected inst%0d %h", k, o_pkt[k], e.inst, e.p);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    pkt_t p;
    int   acc;
    int   cyc;

    for (int k = 0; k < 3; k++) drv_pkt[k] = '0;
    drv_valid = '0; drv_ready = '0; drv_flush = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #6;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_count%0d", k), o_count[k], 0);
      chk($sformatf("rst_valid%0d", k), o_valid[k], 0);
      chk($sformatf("rst_af%0d", k), o_af[k], 0);
    end
    #4 rst_n = 1'b1;
    tick();

    // 1: fill DEPTH 4 with output stalled, then drain in order.
    for (int i = 1; i <= 4; i++) begin
      drv_pkt[0]   = mk(4'(i), 16'(32'h0010 * i), 32'h1111_0000 + 32'(i), 4'hF, 1'b0);
      drv_valid[0] = 1'b1;
      chk("t1_in_ready", i_ready[0], 1);
      expect_out(0, drv_pkt[0]);
      tick();
      chk("t1_count", o_count[0], 64'(i));
      chk("t1_af", o_af[0], (i >= 3) ? 1 : 0);
    end
    drv_pkt[0] = mk(4'd5, 16'h0050, 32'h1111_0005, 4'hF, 1'b0);
    #1 chk("t1_full_ready", i_ready[0], 0);
    tick();
    chk("t1_full_count", o_count[0], 4);
    drv_valid[0] = 1'b0;
    drv_ready[0] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("t1_drain_valid", o_valid[0], 1);
      tick();
      chk("t1_drain_count", o_count[0], 64'(3 - j));
      chk("t1_drain_af", o_af[0], (j == 0) ? 1 : 0);
    end
    chk("t1_empty_valid", o_valid[0], 0);
    drv_ready[0] = 1'b0;

    // 2: DEPTH 3, ten requests offered back to back, output ready toggling.
    drv_ready[1] = 1'b1;
    acc = 0;
    cyc = 0;
    while (acc < 10 && cyc < 100) begin
      drv_pkt[1] = mk(4'(acc), 16'(32'h0100 + acc * 4), 32'hA5A5_0000 ^ (32'(acc) * 32'h0101_0101),
                      4'(acc), acc[0]);
      drv_valid[1] = 1'b1;
      if (i_ready[1]) begin
        expect_out(1, drv_pkt[1]);
        acc++;
      end
      tick();
      drv_ready[1] = ~drv_ready[1];
      cyc++;
    end
    chk("t2_accepted", 64'(acc), 10);
    drv_valid[1] = 1'b0;
    drv_ready[1] = 1'b1;
    cyc = 0;
    while (o_count[1] != 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("t2_drained_count", o_count[1], 0);
    chk("t2_sb_empty", 64'(exp_q.size()), 0);
    drv_ready[1] = 1'b0;

    // 3: fall-through on an empty queue with output ready.
    drv_ready[2] = 1'b1;
    drv_pkt[2]   = mk(4'd5, 16'h0040, 32'hDEAD_BEEF, 4'h0, 1'b1);
    drv_valid[2] = 1'b1;
    expect_out(2, drv_pkt[2]);
    #1;
    chk("t3_valid", o_valid[2], 1);
    chk("t3_addr", o_pkt[2].addr, 16'h0040);
    chk("t3_id", o_pkt[2].id, 5);
    tick();
    chk("t3_count", o_count[2], 0);

    // 4: fall-through mode with entries queued serves the head first.
    drv_ready[2] = 1'b0;
    drv_pkt[2] = mk(4'd7, 16'h0070, 32'h7777_7777, 4'h3, 1'b0);
    expect_out(2, drv_pkt[2]);
    tick();
    drv_pkt[2] = mk(4'd8, 16'h0080, 32'h8888_8888, 4'hC, 1'b0);
    expect_out(2, drv_pkt[2]);
    tick();
    chk("t4_count2", o_count[2], 2);
    drv_pkt[2] = mk(4'd9, 16'h0090, 32'h9999_9999, 4'h0, 1'b0);
    expect_out(2, drv_pkt[2]);
    #1;
    chk("t4_valid", o_valid[2], 1);
    chk("t4_head_id", o_pkt[2].id, 7);
    tick();
    chk("t4_count3", o_count[2], 3);
    drv_valid[2] = 1'b0;
    drv_ready[2] = 1'b1;
    tick(); tick(); tick();
    chk("t4_drained", o_count[2], 0);
    drv_ready[2] = 1'b0;

    // 5: flush with input offered; also flush the empty fall-through queue.
    drv_valid[0] = 1'b1;
    for (int i = 10; i <= 12; i++) begin
      drv_pkt[0] = mk(4'(i), 16'(32'h0200 + i), 32'(i), 4'h1, 1'b1);
      tick();
    end
    chk("t5_count3", o_count[0], 3);
    chk("t5_af", o_af[0], 1);
    drv_pkt[0]   = mk(4'd13, 16'h020D, 32'd13, 4'h1, 1'b1);
    drv_flush[0] = 1'b1;
    drv_ready[0] = 1'b1;
    drv_pkt[2]   = mk(4'd14, 16'h0300, 32'h0000_0300, 4'h2, 1'b0);
    drv_valid[2] = 1'b1;
    drv_flush[2] = 1'b1;
    drv_ready[2] = 1'b1;
    #1;
    chk("t5_flush_in_ready", i_ready[0], 0);
    chk("t5_flush_valid", o_valid[0], 0);
    chk("t5_ft_flush_valid", o_valid[2], 0);
    chk("t5_ft_flush_ready", i_ready[2], 0);
    tick();
    drv_flush = '0;
    drv_valid = '0;
    chk("t5_post_count", o_count[0], 0);
    chk("t5_post_valid", o_valid[0], 0);
    chk("t5_post_af", o_af[0], 0);
    chk("t5_ft_post_count", o_count[2], 0);
    tick();
    chk("t5_not_accepted", o_count[0], 0);
    drv_ready = '0;

    // 6: asynchronous reset with two entries queued, then restart.
    drv_valid[0] = 1'b1;
    drv_pkt[0] = mk(4'd2, 16'h0402, 32'h0000_0402, 4'h5, 1'b0);
    tick();
    drv_pkt[0] = mk(4'd3, 16'h0403, 32'h0000_0403, 4'h6, 1'b0);
    tick();
    drv_valid[0] = 1'b0;
    chk("t6_count2", o_count[0], 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", o_valid[0], 0);
    chk("t6_rst_count", o_count[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drv_ready[0] = 1'b1;
    drv_pkt[0]   = mk(4'd6, 16'h0606, 32'hCAFE_0606, 4'hA, 1'b1);
    drv_valid[0] = 1'b1;
    expect_out(0, drv_pkt[0]);
    #1 chk("t6_latency0_valid", o_valid[0], 0);
    tick();
    drv_valid[0] = 1'b0;
    chk("t6_latency1_valid", o_valid[0], 1);
    chk("t6_latency1_id", o_pkt[0].id, 6);
    tick();
    chk("t6_final_count", o_count[0], 0);
    drv_ready = '0;

    tick();
    chk("sb_drained", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
